// File: rtl/key_set_ctrl.sv
// Two-key time-setting controller: mode key cycles RUN/SET_HOUR/SET_MIN/SET_SEC, inc key strobes the field.
// Optional feature: define KEY_AUTO_REPEAT_EN to enable hold-to-repeat on the inc key.
module key_set_ctrl #(
    parameter int unsigned CLK_FREQ_Hz = 27000000,
    parameter logic        KEY_ACTIVE  = 1'b0,
    parameter int unsigned LONG_MS     = 1000,
    parameter int unsigned REPEAT_MS   = 200,
    parameter int unsigned TIMEOUT_MS  = 10000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mode_key_i,
    input  logic       inc_key_i,
    output logic [1:0] mode_o,
    output logic       run_en_o,
    output logic       inc_hour_o,
    output logic       inc_min_o,
    output logic       inc_sec_o,
    output logic       blink_o
);

    localparam int unsigned DIV      = CLK_FREQ_Hz / 1000;
    localparam int unsigned MS_W     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned BLINK_MS = 250;
    localparam int unsigned BLINK_W  = $clog2(BLINK_MS);
    localparam int unsigned IDLE_W   = $clog2(TIMEOUT_MS + 1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_SET_HOUR = 2'b01,
        ST_SET_MIN  = 2'b10,
        ST_SET_SEC  = 2'b11
    } state_t;

    if ((CLK_FREQ_Hz < 1000) || ((CLK_FREQ_Hz % 1000) != 0) || (LONG_MS == 0) ||
        (REPEAT_MS == 0) || (TIMEOUT_MS == 0)) begin : g_param_error
        $error("key_set_ctrl: illegal parameter value");
    end

    state_t state_q;
    state_t state_d;

    logic [MS_W-1:0]    ms_cnt;
    logic               tick;
    logic               mode_prev;
    logic               inc_prev;
    logic               hist_valid;
    logic               mode_press;
    logic               inc_press;
    logic               inc_held;
    logic               idle_clr;
    logic               mode_change;
    logic [IDLE_W-1:0]  idle_cnt;
    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_q;
    logic               inc_fire;
    logic               hour_stb;
    logic               min_stb;
    logic               sec_stb;
    logic               hold_active;
    logic               rep_fire;

    // ms timebase
    assign tick = (ms_cnt == MS_W'(DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            ms_cnt <= '0;
        end else if (tick) begin
            ms_cnt <= '0;
        end else begin
            ms_cnt <= ms_cnt + 1'b1;
        end
    end

    // hist_valid masks the first post-reset cycle so a key held through reset is never a press
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_prev  <= ~KEY_ACTIVE;
            inc_prev   <= ~KEY_ACTIVE;
            hist_valid <= 1'b0;
        end else begin
            mode_prev  <= mode_key_i;
            inc_prev   <= inc_key_i;
            hist_valid <= 1'b1;
        end
    end

    assign inc_held   = (inc_key_i == KEY_ACTIVE);
    assign mode_press = hist_valid && (mode_key_i == KEY_ACTIVE) && (mode_prev != KEY_ACTIVE);
    assign inc_press  = hist_valid && inc_held && (inc_prev != KEY_ACTIVE);
    assign idle_clr   = mode_press || inc_press || hold_active;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (mode_press) begin
            case (state_q)
                ST_RUN:      state_d = ST_SET_HOUR;
                ST_SET_HOUR: state_d = ST_SET_MIN;
                ST_SET_MIN:  state_d = ST_SET_SEC;
                default:     state_d = ST_RUN;
            endcase
        end else if ((state_q != ST_RUN) && !idle_clr && tick &&
                     (idle_cnt == IDLE_W'(TIMEOUT_MS - 1))) begin
            state_d = ST_RUN;
        end
    end

    assign mode_change = (state_d != state_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt <= '0;
        end else if ((state_q == ST_RUN) || idle_clr || mode_change) begin
            idle_cnt <= '0;
        end else if (tick && (idle_cnt != IDLE_W'(TIMEOUT_MS))) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

`ifdef KEY_AUTO_REPEAT_EN
    localparam int unsigned LONG_W = $clog2(LONG_MS + 1);
    localparam int unsigned REP_W  = $clog2(REPEAT_MS + 1);

    logic              armed;
    logic              long_done;
    logic [LONG_W-1:0] hold_cnt;
    logic [REP_W-1:0]  rep_cnt;

    // armed only by a fresh press in a SET state; any mode change or release disarms
    assign hold_active = armed && inc_held && (state_q != ST_RUN);
    assign long_done   = (hold_cnt == LONG_W'(LONG_MS));
    assign rep_fire    = hold_active && !inc_press && tick &&
                         (long_done ? (rep_cnt == REP_W'(REPEAT_MS - 1))
                                    : (hold_cnt == LONG_W'(LONG_MS - 1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            armed <= 1'b0;
        end else if (mode_change || !inc_held) begin
            armed <= 1'b0;
        end else if (inc_press && (state_q != ST_RUN)) begin
            armed <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !hold_active || mode_change) begin
            hold_cnt <= '0;
            rep_cnt  <= '0;
        end else if (tick) begin
            if (!long_done) begin
                hold_cnt <= hold_cnt + 1'b1;
            end else if (rep_cnt == REP_W'(REPEAT_MS - 1)) begin
                rep_cnt <= '0;
            end else begin
                rep_cnt <= rep_cnt + 1'b1;
            end
        end
    end
`else
    assign hold_active = 1'b0;
    assign rep_fire    = 1'b0;
`endif

    assign inc_fire = !mode_change && (state_q != ST_RUN) && (inc_press || rep_fire);

    always_ff @(posedge clk) begin
        if (rst) begin
            hour_stb <= 1'b0;
            min_stb  <= 1'b0;
            sec_stb  <= 1'b0;
        end else begin
            hour_stb <= inc_fire && (state_q == ST_SET_HOUR);
            min_stb  <= inc_fire && (state_q == ST_SET_MIN);
            sec_stb  <= inc_fire && (state_q == ST_SET_SEC);
        end
    end

    // blink phase restarts high whenever a SET state is entered
    always_ff @(posedge clk) begin
        if (rst) begin
            blink_q   <= 1'b0;
            blink_cnt <= '0;
        end else if (mode_change) begin
            blink_q   <= (state_d != ST_RUN);
            blink_cnt <= '0;
        end else if (state_q == ST_RUN) begin
            blink_q   <= 1'b0;
            blink_cnt <= '0;
        end else if (tick) begin
            if (blink_cnt == BLINK_W'(BLINK_MS - 1)) begin
                blink_q   <= ~blink_q;
                blink_cnt <= '0;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    assign mode_o     = state_q;
    assign run_en_o   = (state_q == ST_RUN);
    assign inc_hour_o = hour_stb & ~rst;
    assign inc_min_o  = min_stb & ~rst;
    assign inc_sec_o  = sec_stb & ~rst;
    assign blink_o    = blink_q;

endmodule
